// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - FSM states, Avalon register map and bit indices for i2c_slave_regs
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic [2:0] REG_BANK0    = 3'd0;
    localparam logic [2:0] REG_BANK1    = 3'd1;
    localparam logic [2:0] REG_BANK2    = 3'd2;
    localparam logic [2:0] REG_BANK3    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_CTRL     = 3'd5;
    localparam logic [2:0] REG_OWN_ADDR = 3'd6;
    localparam logic [2:0] REG_PTR      = 3'd7;

    localparam int STAT_WR_DONE = 0;
    localparam int STAT_RD_DONE = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_RW      = 3;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_ENABLE  = 1;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_slave_sync.sv
// rtl/i2c_slave_sync.sv - SCL/SDA synchronizer, optional majority filter (I2C_SLAVE_GLITCH_FILTER_EN), START/STOP/edge pulses
module i2c_slave_sync
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_f;
    logic                   sda_f;
    logic                   scl_d;
    logic                   sda_d;

    // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_flt;
    logic [2:0] sda_flt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_flt <= '1;
            sda_flt <= '1;
        end else begin
            scl_flt <= {scl_flt[1:0], scl_sync[SYNC_STAGES-1]};
            sda_flt <= {sda_flt[1:0], sda_sync[SYNC_STAGES-1]};
        end
    end

    assign scl_f = maj3(scl_flt);
    assign sda_f = maj3(sda_flt);
`else
    assign scl_f = scl_sync[SYNC_STAGES-1];
    assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign sda       = sda_f;
    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with 4-byte mailbox bank on Avalon-MM; I2C_SLAVE_GLITCH_FILTER_EN adds input filtering
module i2c_slave_regs
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic       write,
    input  logic       chipselect,
    output logic       irq,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       sda_oen, sda_oen_n;
    logic [1:0] ptr, ptr_n;
    logic       rw_bit, rw_n;
    logic       wrote, wrote_n;
    logic       i2c_we;
    logic       set_wr;
    logic       set_rd;
    logic [7:0] byte_in;

    logic [7:0] bank [4];
    logic       wr_done;
    logic       rd_done;
    logic       irq_en;
    logic       enable;
    logic [6:0] own_addr;
    logic       busy;
    logic       av_we;
    logic [7:0] status;

    i2c_slave_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_pad  (scl_pad_i),
        .sda_pad  (sda_pad_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign byte_in = {shreg[6:0], sda};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            sda_oen <= 1'b1;
            ptr     <= '0;
            rw_bit  <= 1'b0;
            wrote   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            sda_oen <= sda_oen_n;
            ptr     <= ptr_n;
            rw_bit  <= rw_n;
            wrote   <= wrote_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        sda_oen_n = sda_oen;
        ptr_n     = ptr;
        rw_n      = rw_bit;
        wrote_n   = wrote;
        i2c_we    = 1'b0;
        set_wr    = 1'b0;
        set_rd    = 1'b0;

        if (stop_det) begin
            state_n   = ST_IDLE;
            sda_oen_n = 1'b1;
            set_wr    = wrote;
            wrote_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = '0;
            sda_oen_n = 1'b1;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw_n = sda;
                            if (byte_in[7:1] == own_addr && enable) begin
                                state_n = ST_ADDR_ACK;
                            end else begin
                                state_n = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                // First fall after the byte pulls SDA low; the next fall ends the ACK pulse.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (sda_oen) begin
                            sda_oen_n = 1'b0;
                        end else begin
                            bit_cnt_n = '0;
                            if (rw_bit) begin
                                state_n   = ST_RD_BYTE;
                                shreg_n   = {bank[ptr][6:0], 1'b0};
                                sda_oen_n = bank[ptr][7];
                                ptr_n     = ptr + 2'd1;
                            end else begin
                                state_n   = ST_PTR;
                                sda_oen_n = 1'b1;
                            end
                        end
                    end
                end
                ST_PTR, ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_n = ST_WR_ACK;
                            if (state == ST_PTR) begin
                                ptr_n = byte_in[1:0];
                            end else begin
                                i2c_we  = 1'b1;
                                ptr_n   = ptr + 2'd1;
                                wrote_n = 1'b1;
                            end
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (sda_oen) begin
                            sda_oen_n = 1'b0;
                        end else begin
                            sda_oen_n = 1'b1;
                            state_n   = ST_WR_BYTE;
                            bit_cnt_n = '0;
                        end
                    end
                end
                // shreg[7] always holds the next bit to present on the following fall.
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oen_n = 1'b1;
                            state_n   = ST_RD_ACK;
                        end else begin
                            sda_oen_n = shreg[7];
                            shreg_n   = {shreg[6:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            state_n   = ST_RD_BYTE;
                            shreg_n   = bank[ptr];
                            ptr_n     = ptr + 2'd1;
                            bit_cnt_n = '0;
                        end else begin
                            set_rd  = 1'b1;
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign av_we = chipselect & write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                bank[i] <= '0;
            end
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            irq_en   <= 1'b0;
            enable   <= 1'b1;
            own_addr <= SLAVE_ADDR;
        end else begin
            if (av_we && !address[2]) begin
                bank[address[1:0]] <= writedata;
            end
            // Later assignment gives the I2C side priority on a collision.
            if (i2c_we) begin
                bank[ptr] <= byte_in;
            end
            if (av_we && address == REG_CTRL) begin
                irq_en <= writedata[CTRL_IRQ_EN];
                enable <= writedata[CTRL_ENABLE];
            end
            if (av_we && address == REG_OWN_ADDR) begin
                own_addr <= writedata[6:0];
            end
            wr_done <= set_wr |
                       (wr_done & ~(av_we && address == REG_STATUS && writedata[STAT_WR_DONE]));
            rd_done <= set_rd |
                       (rd_done & ~(av_we && address == REG_STATUS && writedata[STAT_RD_DONE]));
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        status               = '0;
        status[STAT_WR_DONE] = wr_done;
        status[STAT_RD_DONE] = rd_done;
        status[STAT_BUSY]    = busy;
        status[STAT_RW]      = rw_bit;
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_BANK0, REG_BANK1, REG_BANK2, REG_BANK3: readdata = bank[address[1:0]];
            REG_STATUS:   readdata = status;
            REG_CTRL:     readdata = {6'b0, enable, irq_en};
            REG_OWN_ADDR: readdata = {1'b0, own_addr};
            REG_PTR:      readdata = {6'b0, ptr};
            default:      readdata = '0;
        endcase
    end

    assign irq          = (wr_done | rd_done) & irq_en;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - self-checking bench for i2c_slave_regs (bus master model plus Avalon vectors)
module tb_i2c_slave_regs;

    localparam int SYNC = 2;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int FLT = 2;
`else
    localparam int FLT = 0;
`endif
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] address = '0;
    logic [7:0] writedata = '0;
    logic [7:0] readdata;
    logic       write = 1'b0;
    logic       chipselect = 1'b0;
    logic       irq;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_pad_o;
    logic       sda_padoen_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } av_vec_t;

    av_vec_t reset_vec [8];
    av_vec_t map_vec   [10];

    assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

    always #5 clk = ~clk;

    i2c_slave_regs #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .write       (write),
        .chipselect  (chipselect),
        .irq         (irq),
        .scl_pad_i   (scl_m),
        .sda_pad_i   (sda_bus),
        .sda_pad_o   (sda_pad_o),
        .sda_padoen_o(sda_padoen_o)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic qwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic av_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic run_vec(input av_vec_t v, input string tag);
        logic [7:0] rd;
        if (v.wr) av_write(v.addr, v.wdata);
        av_read(v.addr, rd);
        check($sformatf("%s reg%0d", tag, v.addr), rd, v.exp);
    endtask

    task automatic expect_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        av_read(a, rd);
        check(name, rd, exp);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait(Q);
        scl_m = 1'b1; qwait(Q);
        sda_m = 1'b0; qwait(Q);
        scl_m = 1'b0; qwait(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait(Q);
        scl_m = 1'b1; qwait(Q);
        sda_m = 1'b1; qwait(2 * Q);
    endtask

    // glitch_bit >= 0 pulls SCL low for one clk while that bit is high.
    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = d[i]; qwait(Q);
            scl_m = 1'b1; qwait(Q);
            if (i == glitch_bit) begin
                scl_m = 1'b0; qwait(1);
                scl_m = 1'b1;
            end
            qwait(Q);
            scl_m = 1'b0; qwait(Q);
        end
        sda_m = 1'b1; qwait(Q);
        scl_m = 1'b1; qwait(Q);
        ack = sda_bus; qwait(Q);
        scl_m = 1'b0; qwait(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; qwait(Q);
            scl_m = 1'b1; qwait(Q);
            d[i] = sda_bus; qwait(Q);
            scl_m = 1'b0; qwait(Q);
        end
        sda_m = nack; qwait(Q);
        scl_m = 1'b1; qwait(2 * Q);
        scl_m = 1'b0; qwait(Q);
        sda_m = 1'b1;
    endtask

    task automatic send(input string name, input logic [7:0] d, input logic exp_ack);
        logic ack;
        write_byte(d, -1, ack);
        check(name, {7'b0, ack}, {7'b0, exp_ack});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic       ack;

        reset_vec[0] = '{1'b0, 3'd0, 8'h00, 8'h00};
        reset_vec[1] = '{1'b0, 3'd1, 8'h00, 8'h00};
        reset_vec[2] = '{1'b0, 3'd2, 8'h00, 8'h00};
        reset_vec[3] = '{1'b0, 3'd3, 8'h00, 8'h00};
        reset_vec[4] = '{1'b0, 3'd4, 8'h00, 8'h00};
        reset_vec[5] = '{1'b0, 3'd5, 8'h00, 8'h02};
        reset_vec[6] = '{1'b0, 3'd6, 8'h00, 8'h50};
        reset_vec[7] = '{1'b0, 3'd7, 8'h00, 8'h00};

        map_vec[0] = '{1'b1, 3'd0, 8'hA5, 8'hA5};
        map_vec[1] = '{1'b1, 3'd3, 8'h3C, 8'h3C};
        map_vec[2] = '{1'b1, 3'd7, 8'hFF, 8'h00};
        map_vec[3] = '{1'b1, 3'd4, 8'h04, 8'h00};
        map_vec[4] = '{1'b1, 3'd5, 8'hFF, 8'h03};
        map_vec[5] = '{1'b1, 3'd6, 8'hD5, 8'h55};
        map_vec[6] = '{1'b0, 3'd0, 8'h00, 8'hA5};
        map_vec[7] = '{1'b1, 3'd6, 8'h50, 8'h50};
        map_vec[8] = '{1'b1, 3'd5, 8'h03, 8'h03};
        map_vec[9] = '{1'b0, 3'd1, 8'h00, 8'h00};

        qwait(3);
        reset_n = 1'b1;
        qwait(2);

        for (int i = 0; i < 8; i++) run_vec(reset_vec[i], "reset");
        check("reset irq", {7'b0, irq}, 8'h00);
        check("reset sda_padoen_o", {7'b0, sda_padoen_o}, 8'h01);
        check("sda_pad_o", {7'b0, sda_pad_o}, 8'h00);

        for (int i = 0; i < 10; i++) run_vec(map_vec[i], "map");
        check("map irq", {7'b0, irq}, 8'h00);

        // Write transaction: pointer 1, two data bytes.
        i2c_start();
        send("t1 addr ack", 8'hA0, 1'b0);
        send("t1 ptr ack", 8'h01, 1'b0);
        send("t1 d0 ack", 8'h11, 1'b0);
        send("t1 d1 ack", 8'h22, 1'b0);
        i2c_stop();
        expect_reg("t1 bank1", 3'd1, 8'h11);
        expect_reg("t1 bank2", 3'd2, 8'h22);
        expect_reg("t1 bank0", 3'd0, 8'hA5);
        expect_reg("t1 ptr", 3'd7, 8'h03);
        expect_reg("t1 status", 3'd4, 8'h01);
        check("t1 irq", {7'b0, irq}, 8'h01);
        av_write(3'd4, 8'h03);
        expect_reg("t1 status w1c", 3'd4, 8'h00);
        check("t1 irq cleared", {7'b0, irq}, 8'h00);

        // Combined write-pointer / repeated START / read of two bytes.
        av_write(3'd3, 8'h5A);
        av_write(3'd0, 8'hC3);
        i2c_start();
        send("t2 addr w ack", 8'hA0, 1'b0);
        send("t2 ptr ack", 8'h03, 1'b0);
        i2c_start();
        send("t2 addr r ack", 8'hA1, 1'b0);
        read_byte(1'b0, rd);
        check("t2 rd0", rd, 8'h5A);
        read_byte(1'b1, rd);
        check("t2 rd1", rd, 8'hC3);
        i2c_stop();
        expect_reg("t2 status", 3'd4, 8'h0A);
        expect_reg("t2 ptr", 3'd7, 8'h01);
        check("t2 irq", {7'b0, irq}, 8'h01);
        av_write(3'd4, 8'h03);
        expect_reg("t2 status w1c", 3'd4, 8'h08);

        // Foreign address: no ACK, busy until STOP, bank untouched.
        i2c_start();
        send("t3 addr nack", 8'hA2, 1'b1);
        expect_reg("t3 busy", 3'd4, 8'h04);
        send("t3 data nack", 8'h55, 1'b1);
        expect_reg("t3 still busy", 3'd4, 8'h04);
        i2c_stop();
        expect_reg("t3 idle", 3'd4, 8'h00);
        expect_reg("t3 bank2", 3'd2, 8'h22);
        expect_reg("t3 ptr", 3'd7, 8'h01);

        // Disabled target NACKs its own address; re-enabled it ACKs.
        av_write(3'd5, 8'h01);
        i2c_start();
        send("t4 disabled nack", 8'hA0, 1'b1);
        i2c_stop();
        av_write(3'd5, 8'h03);
        i2c_start();
        send("t4 enabled ack", 8'hA0, 1'b0);
        i2c_stop();
        expect_reg("t4 status", 3'd4, 8'h00);

        // W1C of wr_done in the same clk as the STOP that sets it.
        i2c_start();
        send("t5 addr ack", 8'hA0, 1'b0);
        send("t5 ptr ack", 8'h00, 1'b0);
        send("t5 data ack", 8'h77, 1'b0);
        sda_m = 1'b0; qwait(Q);
        scl_m = 1'b1; qwait(Q);
        sda_m = 1'b1;
        repeat (SYNC + FLT) @(negedge clk);
        address = 3'd4; writedata = 8'h03; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        qwait(2 * Q);
        expect_reg("t5 wr_done set wins", 3'd4, 8'h01);
        expect_reg("t5 bank0", 3'd0, 8'h77);
        av_write(3'd4, 8'h03);

        // Reset while the target is pulling SDA low during a read.
        av_write(3'd2, 8'h0F);
        i2c_start();
        send("t6 addr w ack", 8'hA0, 1'b0);
        send("t6 ptr ack", 8'h02, 1'b0);
        i2c_start();
        send("t6 addr r ack", 8'hA1, 1'b0);
        check("t6 sda driven", {7'b0, sda_padoen_o}, 8'h00);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("t6 async release", {7'b0, sda_padoen_o}, 8'h01);
        sda_m = 1'b1; qwait(Q);
        scl_m = 1'b1; qwait(Q);
        reset_n = 1'b1;
        qwait(Q);
        for (int i = 0; i < 8; i++) run_vec(reset_vec[i], "t6 post-reset");
        check("t6 irq", {7'b0, irq}, 8'h00);
        check("t6 sda_padoen_o", {7'b0, sda_padoen_o}, 8'h01);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-clk SCL low glitch inside a data bit must be filtered out.
        i2c_start();
        send("t7 addr ack", 8'hA0, 1'b0);
        send("t7 ptr ack", 8'h01, 1'b0);
        write_byte(8'hB6, 4, ack);
        check("t7 glitch ack", {7'b0, ack}, 8'h00);
        i2c_stop();
        expect_reg("t7 bank1", 3'd1, 8'hB6);
        expect_reg("t7 ptr", 3'd7, 8'h02);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
